// File: rtl/onchip_memory_arbiter_pkg.sv
// Shared types and default sizing for the two-port on-chip RAM arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package onchip_memory_arbiter_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 3072;

  // ARB: ports arbitrate for the RAM; FILL: fill engine owns the RAM.
  typedef enum logic {
    ARB  = 1'b0,
    FILL = 1'b1
  } state_e;

  typedef enum logic {
    PORT_S1 = 1'b0,
    PORT_S2 = 1'b1
  } port_e;

endpackage

// File: rtl/onchip_memory_arbiter_rr.sv
// Two-way round-robin arbiter with a combinational one-hot grant.
// Latency: grant in the same cycle as the request; pointer updates on the clock.
// Backpressure: en_i=0 suppresses all grants and freezes the pointer.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (pointer -> PORT_S1)
//   en_i         grants allowed this cycle
//   req_i[1:0]   requests, bit 0 = s1, bit 1 = s2
//   gnt_o[1:0]   one-hot grant, same bit order as req_i
module rr_arbiter_2
  import onchip_memory_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  port_e ptr_q, ptr_d;

  always_comb begin
    gnt_o = 2'b00;
    ptr_d = ptr_q;
    if (en_i) begin
      case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = (ptr_q == PORT_S1) ? 2'b01 : 2'b10;
        default: gnt_o = 2'b00;
      endcase
      // Winner yields priority to the other port next time.
      if (gnt_o[0]) begin
        ptr_d = PORT_S2;
      end else if (gnt_o[1]) begin
        ptr_d = PORT_S1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= PORT_S1;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/onchip_memory_arbiter.sv
// Shares one single-port RAM between two Avalon-MM slaves (round-robin) and
// provides a fill engine that writes a constant to every implemented word.
// Latency: grant/write in the request cycle; readdatavalid one cycle after the
// accepted read. Backpressure: waitrequest=1 for the losing port, and for both
// ports during reset and throughout a fill (DEPTH cycles).
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   s1_* / s2_*           Avalon-MM slave ports (address, byteenable, chipselect,
//                         read, write, writedata, readdata, readdatavalid,
//                         waitrequest)
//   fill_start/value      fill request pulse and constant to write
//   fill_busy/done        fill in progress / one-cycle completion pulse
//   mem_*                 RAM master side; mem_readdata arrives one cycle late
module onchip_memory_arbiter
  import onchip_memory_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                clk,
  input  logic                reset_n,

  input  logic [ADDR_W-1:0]   s1_address,
  input  logic [DATA_W/8-1:0] s1_byteenable,
  input  logic                s1_chipselect,
  input  logic                s1_read,
  input  logic                s1_write,
  input  logic [DATA_W-1:0]   s1_writedata,
  output logic [DATA_W-1:0]   s1_readdata,
  output logic                s1_readdatavalid,
  output logic                s1_waitrequest,

  input  logic [ADDR_W-1:0]   s2_address,
  input  logic [DATA_W/8-1:0] s2_byteenable,
  input  logic                s2_chipselect,
  input  logic                s2_read,
  input  logic                s2_write,
  input  logic [DATA_W-1:0]   s2_writedata,
  output logic [DATA_W-1:0]   s2_readdata,
  output logic                s2_readdatavalid,
  output logic                s2_waitrequest,

  input  logic                fill_start,
  input  logic [DATA_W-1:0]   fill_value,
  output logic                fill_busy,
  output logic                fill_done,

  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata
);

  // Fill stops at the last implemented word, not at the top of the address space.
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]   fval_q, fval_d;
  logic                done_q, done_d;
  logic                rdv1_q, rdv1_d;
  logic                rdv2_q, rdv2_d;

  logic                s1_req, s2_req;
  logic                arb_en;
  logic [1:0]          gnt;

  assign s1_req = s1_chipselect & (s1_read | s1_write);
  assign s2_req = s2_chipselect & (s2_read | s2_write);

  // Gating with reset_n keeps both ports stalled while reset is held, even
  // though the grant path is purely combinational.
  assign arb_en = reset_n && (state_q == ARB);

  rr_arbiter_2 u_arb (
    .clk   (clk),
    .rst_n (reset_n),
    .en_i  (arb_en),
    .req_i ({s2_req, s1_req}),
    .gnt_o (gnt)
  );

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    fval_d         = fval_q;
    done_d         = 1'b0;
    // Read+write together is a write: no read response.
    rdv1_d         = gnt[0] & s1_read & ~s1_write;
    rdv2_d         = gnt[1] & s2_read & ~s2_write;
    s1_waitrequest = ~gnt[0];
    s2_waitrequest = ~gnt[1];
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    mem_address    = s1_address;
    mem_byteenable = s1_byteenable;
    mem_writedata  = s1_writedata;

    case (state_q)
      ARB: begin
        if (gnt[1]) begin
          mem_address    = s2_address;
          mem_byteenable = s2_byteenable;
          mem_writedata  = s2_writedata;
        end
        if (gnt != 2'b00) begin
          mem_chipselect = 1'b1;
          mem_write      = gnt[0] ? s1_write : s2_write;
        end
        // The access granted in this cycle still completes normally.
        if (fill_start) begin
          state_d = FILL;
          cnt_d   = '0;
          fval_d  = fill_value;
        end
      end
      FILL: begin
        mem_chipselect = 1'b1;
        mem_write      = 1'b1;
        mem_address    = cnt_q;
        mem_byteenable = '1;
        mem_writedata  = fval_q;
        if (cnt_q == LAST_ADDR) begin
          state_d = ARB;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ARB;
      cnt_q   <= '0;
      fval_q  <= '0;
      done_q  <= 1'b0;
      rdv1_q  <= 1'b0;
      rdv2_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fval_q  <= fval_d;
      done_q  <= done_d;
      rdv1_q  <= rdv1_d;
      rdv2_q  <= rdv2_d;
    end
  end

  // RAM data arrives one cycle after the address, aligned with the valid flags.
  assign s1_readdata      = mem_readdata;
  assign s2_readdata      = mem_readdata;
  assign s1_readdatavalid = rdv1_q;
  assign s2_readdatavalid = rdv2_q;
  assign fill_busy        = (state_q == FILL);
  assign fill_done        = done_q;
  assign mem_clken        = 1'b1;

endmodule

// File: tb/tb_onchip_memory_arbiter.sv
module tb_onchip_memory_arbiter;

  logic        clk;
  logic        reset_n;
  logic [11:0] s1_address, s2_address;
  logic [3:0]  s1_byteenable, s2_byteenable;
  logic        s1_chipselect, s1_read, s1_write;
  logic        s2_chipselect, s2_read, s2_write;
  logic [31:0] s1_writedata, s2_writedata;
  logic [31:0] s1_readdata, s2_readdata;
  logic        s1_readdatavalid, s2_readdatavalid;
  logic        s1_waitrequest, s2_waitrequest;
  logic        fill_start;
  logic [31:0] fill_value;
  logic        fill_busy, fill_done;
  logic [11:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [31:0] mem_writedata, mem_readdata;

  int n_chk = 0;
  int n_err = 0;

  onchip_memory_arbiter dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .s1_address       (s1_address),
    .s1_byteenable    (s1_byteenable),
    .s1_chipselect    (s1_chipselect),
    .s1_read          (s1_read),
    .s1_write         (s1_write),
    .s1_writedata     (s1_writedata),
    .s1_readdata      (s1_readdata),
    .s1_readdatavalid (s1_readdatavalid),
    .s1_waitrequest   (s1_waitrequest),
    .s2_address       (s2_address),
    .s2_byteenable    (s2_byteenable),
    .s2_chipselect    (s2_chipselect),
    .s2_read          (s2_read),
    .s2_write         (s2_write),
    .s2_writedata     (s2_writedata),
    .s2_readdata      (s2_readdata),
    .s2_readdatavalid (s2_readdatavalid),
    .s2_waitrequest   (s2_waitrequest),
    .fill_start       (fill_start),
    .fill_value       (fill_value),
    .fill_busy        (fill_busy),
    .fill_done        (fill_done),
    .mem_address      (mem_address),
    .mem_byteenable   (mem_byteenable),
    .mem_chipselect   (mem_chipselect),
    .mem_write        (mem_write),
    .mem_writedata    (mem_writedata),
    .mem_clken        (mem_clken),
    .mem_readdata     (mem_readdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM model: byte-enabled write, registered read.
  logic [31:0] ram [0:3071];
  logic        ram_init_done = 1'b0;

  always @(posedge clk) begin
    if (!ram_init_done) begin
      for (int i = 0; i < 3072; i++) ram[i] <= 32'hC0DE0000 | 32'(i);
      ram_init_done <= 1'b1;
    end else if (mem_chipselect && mem_clken) begin
      if (mem_write) begin
        if (mem_address < 12'd3072) begin
          for (int b = 0; b < 4; b++) begin
            if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
          end
        end
      end else begin
        mem_readdata <= (mem_address < 12'd3072) ? ram[mem_address] : 32'h0BAD0BAD;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_all();
    s1_chipselect = 1'b0; s1_read = 1'b0; s1_write = 1'b0;
    s2_chipselect = 1'b0; s2_read = 1'b0; s2_write = 1'b0;
    fill_start    = 1'b0;
  endtask

  task automatic do_write(input int port, input logic [11:0] addr, input logic [31:0] data,
                          input logic [3:0] be, input string tag);
    @(negedge clk);
    idle_all();
    if (port == 1) begin
      s1_chipselect = 1'b1; s1_write = 1'b1; s1_address = addr;
      s1_byteenable = be;   s1_writedata = data;
    end else begin
      s2_chipselect = 1'b1; s2_write = 1'b1; s2_address = addr;
      s2_byteenable = be;   s2_writedata = data;
    end
    #1;
    check({tag, "_wait"}, (port == 1) ? s1_waitrequest : s2_waitrequest, 32'd0);
  endtask

  task automatic do_read(input int port, input logic [11:0] addr, input logic [31:0] exp,
                         input string tag);
    @(negedge clk);
    idle_all();
    if (port == 1) begin
      s1_chipselect = 1'b1; s1_read = 1'b1; s1_address = addr; s1_byteenable = 4'hF;
    end else begin
      s2_chipselect = 1'b1; s2_read = 1'b1; s2_address = addr; s2_byteenable = 4'hF;
    end
    #1;
    check({tag, "_wait"}, (port == 1) ? s1_waitrequest : s2_waitrequest, 32'd0);
    @(negedge clk);
    idle_all();
    #1;
    check({tag, "_rdv"},  (port == 1) ? s1_readdatavalid : s2_readdatavalid, 32'd1);
    check({tag, "_data"}, (port == 1) ? s1_readdata : s2_readdata, exp);
  endtask

  // overlap=1: s2 read accepted with fill_start, plus a second fill_start mid-fill.
  // overlap=0: s1 holds a read of word 3071 for the whole fill.
  task automatic fill_run(input logic [31:0] val, input bit overlap, input string tag);
    int busy_cyc = 0;
    int wviol = 0;
    int aviol = 0;
    int dviol = 0;
    @(negedge clk);
    idle_all();
    fill_start = 1'b1;
    fill_value = val;
    if (overlap) begin
      s2_chipselect = 1'b1; s2_read = 1'b1; s2_address = 12'd30;
    end
    #1;
    if (overlap) check({tag, "_s2_grant"}, s2_waitrequest, 32'd0);
    check({tag, "_busy_pre"}, fill_busy, 32'd0);
    @(negedge clk);
    idle_all();
    fill_value = ~val;
    if (!overlap) begin
      s1_chipselect = 1'b1; s1_read = 1'b1; s1_address = 12'd3071;
    end
    #1;
    if (overlap) begin
      check({tag, "_s2_rdv"},  s2_readdatavalid, 32'd1);
      check({tag, "_s2_data"}, s2_readdata, 32'hC0DE001E);
    end
    while (fill_busy && busy_cyc < 4000) begin
      busy_cyc++;
      if (s1_waitrequest !== 1'b1 || s2_waitrequest !== 1'b1) wviol++;
      if (mem_chipselect !== 1'b1 || mem_write !== 1'b1 || mem_writedata !== val ||
          mem_byteenable !== 4'hF || mem_address !== 12'(busy_cyc - 1)) aviol++;
      if (fill_done !== 1'b0) dviol++;
      @(negedge clk);
      fill_start = overlap && (busy_cyc == 10);
      #1;
    end
    check({tag, "_busy_cycles"}, 32'(busy_cyc), 32'd3072);
    check({tag, "_wait_viol"},   32'(wviol), 32'd0);
    check({tag, "_mem_viol"},    32'(aviol), 32'd0);
    check({tag, "_early_done"},  32'(dviol), 32'd0);
    check({tag, "_done"},        fill_done, 32'd1);
    if (!overlap) check({tag, "_s1_grant_after"}, s1_waitrequest, 32'd0);
    @(negedge clk);
    idle_all();
    #1;
    check({tag, "_done_pulse"}, fill_done, 32'd0);
    check({tag, "_busy_after"}, fill_busy, 32'd0);
    if (!overlap) begin
      check({tag, "_s1_rdv"},  s1_readdatavalid, 32'd1);
      check({tag, "_s1_data"}, s1_readdata, val);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int guard;
    reset_n = 1'b0;
    idle_all();
    fill_value    = 32'h0;
    s1_writedata  = 32'h0;
    s2_writedata  = 32'h0;
    s1_byteenable = 4'hF;
    s2_byteenable = 4'hF;
    // Both ports request through reset; contention starts at release.
    s1_chipselect = 1'b1; s1_read = 1'b1; s1_address = 12'd20;
    s2_chipselect = 1'b1; s2_read = 1'b1; s2_address = 12'd21;
    repeat (2) @(negedge clk);
    #1;
    check("rst_s1_wait", s1_waitrequest,   32'd1);
    check("rst_s2_wait", s2_waitrequest,   32'd1);
    check("rst_s1_rdv",  s1_readdatavalid, 32'd0);
    check("rst_s2_rdv",  s2_readdatavalid, 32'd0);
    check("rst_busy",    fill_busy,        32'd0);
    check("rst_done",    fill_done,        32'd0);
    check("rst_mem_cs",  mem_chipselect,   32'd0);
    check("rst_mem_wr",  mem_write,        32'd0);
    check("rst_clken",   mem_clken,        32'd1);

    // Contention from reset: s1, s2, s1, s2, ...
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      check($sformatf("cont%0d_s1_wait", k), s1_waitrequest, 32'((k % 2) != 0));
      check($sformatf("cont%0d_s2_wait", k), s2_waitrequest, 32'((k % 2) == 0));
      if (k > 0) begin
        check($sformatf("cont%0d_s1_rdv", k), s1_readdatavalid, 32'(((k - 1) % 2) == 0));
        check($sformatf("cont%0d_s2_rdv", k), s2_readdatavalid, 32'(((k - 1) % 2) != 0));
        if (((k - 1) % 2) == 0) check($sformatf("cont%0d_s1_data", k), s1_readdata, 32'hC0DE0014);
        else                    check($sformatf("cont%0d_s2_data", k), s2_readdata, 32'hC0DE0015);
      end
    end
    @(negedge clk);
    idle_all();
    #1;
    check("cont_last_s2_rdv",  s2_readdatavalid, 32'd1);
    check("cont_last_s2_data", s2_readdata,      32'hC0DE0015);
    check("cont_last_s1_rdv",  s1_readdatavalid, 32'd0);

    // Single-port write then read.
    do_write(1, 12'd5, 32'hDEADBEEF, 4'hF, "sp_wr");
    check("sp_wr_mem_cs",   mem_chipselect, 32'd1);
    check("sp_wr_mem_wr",   mem_write,      32'd1);
    check("sp_wr_mem_addr", mem_address,    32'd5);
    check("sp_wr_mem_wd",   mem_writedata,  32'hDEADBEEF);
    do_read(1, 12'd5, 32'hDEADBEEF, "sp_rd");

    // Byte enables merge into the stored word.
    do_write(1, 12'd7, 32'h11223344, 4'hF, "be_wr0");
    do_write(2, 12'd7, 32'hAABBCCDD, 4'h5, "be_wr1");
    do_read(1, 12'd7, 32'h11BB33DD, "be_rd");

    // Read and write together behave as a write with no response.
    do_write(2, 12'd8, 32'h00000055, 4'hF, "rw_wr");
    s2_read = 1'b1;
    @(negedge clk);
    idle_all();
    #1;
    check("rw_no_rdv", s2_readdatavalid, 32'd0);
    do_read(2, 12'd8, 32'h00000055, "rw_rd");

    // Fill overlapping an s2 read, with a stray fill_start during the fill.
    fill_run(32'hA5A5A5A5, 1'b1, "fillA");
    do_read(2, 12'd30, 32'hA5A5A5A5, "fillA_rd30");

    // Clearing fill, then spot reads across the array.
    fill_run(32'h00000000, 1'b0, "fill0");
    do_read(1, 12'd0,    32'h0, "fill0_rd0");
    do_read(2, 12'd1535, 32'h0, "fill0_rd1535");

    // Reset in the middle of a fill.
    @(negedge clk);
    idle_all();
    fill_start = 1'b1;
    fill_value = 32'h12345678;
    @(negedge clk);
    fill_start = 1'b0;
    #1;
    guard = 0;
    while (mem_address !== 12'd100 && guard < 500) begin
      guard++;
      @(negedge clk);
      #1;
    end
    check("mid_reach100", mem_address, 32'd100);
    check("mid_busy",     fill_busy,   32'd1);
    reset_n = 1'b0;
    s1_chipselect = 1'b1; s1_read = 1'b1; s1_address = 12'd0;
    s2_chipselect = 1'b1; s2_read = 1'b1; s2_address = 12'd1;
    #1;
    check("mid_rst_busy",    fill_busy,      32'd0);
    check("mid_rst_s1_wait", s1_waitrequest, 32'd1);
    check("mid_rst_s2_wait", s2_waitrequest, 32'd1);
    check("mid_rst_mem_cs",  mem_chipselect, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("mid_rel_s1_wait", s1_waitrequest, 32'd0);
    check("mid_rel_s2_wait", s2_waitrequest, 32'd1);
    check("mid_rel_done",    fill_done,      32'd0);
    check("mid_rel_busy",    fill_busy,      32'd0);
    @(negedge clk);
    idle_all();
    #1;
    check("mid_rel_done2",  fill_done,        32'd0);
    check("mid_rel_s1_rdv", s1_readdatavalid, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
